// File: rtl/rom_arbiter_pkg.sv
// Shared constants and types for the ROM read arbiter.
package rom_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF  = 3;
  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned GRANT_CNT_WIDTH = 16;

  localparam bit PORT_FETCH = 1'b0;
  localparam bit PORT_LOAD  = 1'b1;

  // One outstanding ROM read: valid flag plus the port that will receive it.
  typedef struct packed {
    logic vld;
    logic id;
  } infl_t;

endpackage

// File: rtl/rom_arb_pick.sv
// Two-requester grant selection: fixed priority to port 0, or round-robin
// against last_grant when RR_EN is set. Produces a one-hot (or zero) grant.
module rom_arb_pick #(
  parameter bit RR_EN = 1'b0
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  logic port1_turn;

  // Port 1 wins a tie only in round-robin mode after port 0 was served last.
  assign port1_turn = RR_EN && !last_grant;

  always_comb begin
    grant = 2'b00;
    if (valid[0] && !(valid[1] && port1_turn)) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two read ports onto one registered-read ROM and returns data to
// the issuing port one cycle later. Define ROM_ARB_RR_EN for round-robin.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic [ADDR_WIDTH-1:0]      req0_addr,
  output logic                       req0_ready,
  output logic                       rsp0_valid,
  output logic [DATA_WIDTH-1:0]      rsp0_data,
  input  logic                       req1_valid,
  input  logic [ADDR_WIDTH-1:0]      req1_addr,
  output logic                       req1_ready,
  output logic                       rsp1_valid,
  output logic [DATA_WIDTH-1:0]      rsp1_data,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [DATA_WIDTH-1:0]      rom_q,
  output logic [GRANT_CNT_WIDTH-1:0] grant_cnt
);

`ifdef ROM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic [1:0]                 grant;
  logic                       pick_last;
  logic [ADDR_WIDTH-1:0]      sel_addr;

  infl_t                      infl_q, infl_d;
  logic [ADDR_WIDTH-1:0]      last_addr_q, last_addr_d;
  logic [DATA_WIDTH-1:0]      data0_q, data0_d;
  logic [DATA_WIDTH-1:0]      data1_q, data1_d;
  logic [GRANT_CNT_WIDTH-1:0] cnt_q, cnt_d;

  rom_arb_pick #(
    .RR_EN (RR_EN)
  ) u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (pick_last),
    .grant      (grant)
  );

`ifdef ROM_ARB_RR_EN
  logic last_grant;

  // Remembers which port was served last; starts at 1 so port 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

  assign pick_last = last_grant;
`else
  assign pick_last = 1'b1;
`endif

  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Hold the last granted address when idle to avoid toggling the ROM bus.
  assign rom_addr   = (|grant) ? sel_addr : last_addr_q;

  assign rsp0_valid = infl_q.vld && (infl_q.id == PORT_FETCH);
  assign rsp1_valid = infl_q.vld && (infl_q.id == PORT_LOAD);
  assign rsp0_data  = rsp0_valid ? rom_q : data0_q;
  assign rsp1_data  = rsp1_valid ? rom_q : data1_q;
  assign grant_cnt  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q      <= '0;
      last_addr_q <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
      cnt_q       <= '0;
    end else begin
      infl_q      <= infl_d;
      last_addr_q <= last_addr_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    infl_d      = '0;
    last_addr_d = last_addr_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    cnt_d       = cnt_q;
    if (|grant) begin
      infl_d.vld  = 1'b1;
      infl_d.id   = grant[1];
      last_addr_d = sel_addr;
      cnt_d       = cnt_q + GRANT_CNT_WIDTH'(1);
    end
    if (rsp0_valid) data0_d = rom_q;
    if (rsp1_valid) data1_d = rom_q;
  end

endmodule
